stream_decompressor: RTL and testbench



---
 rtl/decomp_pkg.sv | 15 +
 rtl/record_expander.sv | 27 ++
 rtl/stream_decompressor.sv | 58 +++++
 tb/tb_stream_decompressor.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/decomp_pkg.sv
// decomp_pkg: shared widths, tag codes and payload-width helper for the stream decompressor
package decomp_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_DATA = 8;
  localparam int TAG_WIDTH = 2;
  typedef enum logic [TAG_WIDTH-1:0] {
    TAG_ZERO = 2'b00,
    TAG_B8   = 2'b01,
    TAG_B16  = 2'b10,
    TAG_RAW  = 2'b11
  } tag_e;
  function automatic logic [5:0] tag_bits(input tag_e tag);
    return tag == TAG_ZERO ? 6'd0 : tag == TAG_B8 ? 6'd8 : tag == TAG_B16 ? 6'd16 : 6'd32;
  endfunction
endpackage

// File: rtl/record_expander.sv
// record_expander: parses one record at the buffer head into eight words and its bit length
module record_expander
  import decomp_pkg::*;
(
  input  logic [NUM_DATA*(TAG_WIDTH+DATA_WIDTH)-1:0] rec,
  output logic [NUM_DATA*DATA_WIDTH-1:0]             words,
  output logic [8:0]                                 len
);
  logic [8:0] off [NUM_DATA+1];
  // Payloads start right after the tag field; each lane's offset is a running sum of widths.
  always_comb begin
    off[0] = 9'(NUM_DATA*TAG_WIDTH);
    for (int i = 0; i < NUM_DATA; i++)
      off[i+1] = off[i] + 9'(tag_bits(tag_e'(rec[TAG_WIDTH*i +: TAG_WIDTH])));
  end
  for (genvar l = 0; l < NUM_DATA; l++) begin : g_lane
    tag_e tag;
    logic [DATA_WIDTH-1:0] raw;
    assign tag = tag_e'(rec[TAG_WIDTH*l +: TAG_WIDTH]);
    assign raw = DATA_WIDTH'(rec >> off[l]);
    assign words[DATA_WIDTH*l +: DATA_WIDTH] =
      tag == TAG_ZERO ? '0 :
      tag == TAG_B8   ? {{(DATA_WIDTH-8){raw[7]}}, raw[7:0]} :
      tag == TAG_B16  ? {{(DATA_WIDTH-16){raw[15]}}, raw[15:0]} : raw;
  end
  assign len = off[NUM_DATA];
endmodule

// File: rtl/stream_decompressor.sv
// stream_decompressor: bit-buffers the packed record stream and emits one expanded record per handshake
module stream_decompressor
  import decomp_pkg::*;
(
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            wrt_en,
  input  logic                            flush,
  input  logic [NUM_DATA*DATA_WIDTH-1:0]  data_in,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [NUM_DATA*DATA_WIDTH-1:0]  data_out,
  output logic                            out_valid,
  input  logic                            out_ready
);
  localparam int IN_WIDTH = NUM_DATA*DATA_WIDTH;
  localparam int BUF_WIDTH = 2*IN_WIDTH + 32;
  localparam int MAX_REC = NUM_DATA*(TAG_WIDTH+DATA_WIDTH);
  localparam int FILL_LIMIT = BUF_WIDTH - IN_WIDTH;
  logic [BUF_WIDTH-1:0] bits_q, bits_d;
  logic [9:0] fill_q, fill_d, consumed, rem;
  logic [IN_WIDTH-1:0] words, data_out_q, data_out_d;
  logic [8:0] len;
  logic out_valid_q, out_valid_d, extract, accept;
  record_expander u_exp (
    .rec   (bits_q[MAX_REC-1:0]),
    .words (words),
    .len   (len)
  );
  // Bits above fill are kept zero, so shifting and OR-ing in the new word is enough.
  always_comb begin
    extract = wrt_en && fill_q >= 10'(NUM_DATA*TAG_WIDTH) && fill_q >= {1'b0, len}
              && (!out_valid_q || out_ready);
    consumed = extract ? {1'b0, len} : '0;
    rem = fill_q - consumed;
    in_ready = wrt_en && !flush && rem <= 10'(FILL_LIMIT);
    accept = in_valid && in_ready;
    bits_d = flush ? '0 : (bits_q >> consumed) | (accept ? (BUF_WIDTH'(data_in) << rem) : '0);
    fill_d = flush ? '0 : rem + (accept ? 10'(IN_WIDTH) : '0);
    out_valid_d = extract || (out_valid_q && !out_ready);
    data_out_d = extract ? words : data_out_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      bits_q <= '0;
      fill_q <= '0;
      out_valid_q <= 1'b0;
      data_out_q <= '0;
    end else if (wrt_en) begin
      bits_q <= bits_d;
      fill_q <= fill_d;
      out_valid_q <= out_valid_d;
      data_out_q <= data_out_d;
    end
  end
  assign data_out = data_out_q;
  assign out_valid = out_valid_q;
endmodule

// File: tb/tb_stream_decompressor.sv
// tb_stream_decompressor: directed and random records encoded by a bit-level model, checked in order
module tb_stream_decompressor;
  logic clk = 1'b0, reset = 1'b1, wrt_en = 1'b1, flush = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [255:0] data_in = '0, data_out;
  logic in_ready, out_valid;
  int errs = 0, chks = 0;
  bit sq[$];
  logic [255:0] wq[$], eq[$];

  always #5 clk = ~clk;

  stream_decompressor dut (
    .clk(clk), .reset(reset), .wrt_en(wrt_en), .flush(flush),
    .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    chks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Encoder model: tags, then each lane's payload LSB-first; the expected word is its sign-extension.
  task automatic add_rec(input logic [15:0] tags, input logic [255:0] vals);
    logic [31:0] v, w;
    logic [255:0] r;
    int nb;
    r = '0;
    for (int b = 0; b < 16; b++) sq.push_back(tags[b]);
    for (int i = 0; i < 8; i++) begin
      v = vals[32*i +: 32];
      case (tags[2*i +: 2])
        2'd0: begin w = '0; nb = 0; end
        2'd1: begin w = {{24{v[7]}}, v[7:0]}; nb = 8; end
        2'd2: begin w = {{16{v[15]}}, v[15:0]}; nb = 16; end
        default: begin w = v; nb = 32; end
      endcase
      for (int b = 0; b < nb; b++) sq.push_back(v[b]);
      r[32*i +: 32] = w;
    end
    eq.push_back(r);
  endtask

  task automatic rand_vals(output logic [255:0] v);
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
  endtask

  task automatic rand_rec();
    logic [255:0] v;
    rand_vals(v);
    add_rec(16'($urandom), v);
  endtask

  // Trailing all-ones padding reads as an incomplete all-raw record, never a spurious one.
  task automatic seal();
    logic [255:0] w;
    while (sq.size() % 256 != 0) sq.push_back(1'b1);
    while (sq.size() != 0) begin
      for (int j = 0; j < 256; j++) w[j] = sq.pop_front();
      wq.push_back(w);
    end
  endtask

  task automatic tick();
    bit acc;
    logic [255:0] exp;
    #4;
    if (out_valid && out_ready) begin
      exp = eq.size() != 0 ? eq.pop_front() : 'x;
      check("record", data_out, exp);
    end
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
    if (acc) void'(wq.pop_front());
  endtask

  task automatic drain(input int budget, input bit rnd);
    int n = 0;
    while ((wq.size() != 0 || eq.size() != 0) && n < budget) begin
      in_valid = wq.size() != 0 && (!rnd || $urandom_range(0, 3) != 0);
      data_in = wq.size() != 0 ? wq[0] : '0;
      out_ready = !rnd || $urandom_range(0, 2) != 0;
      tick();
      n++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("drain_left", 256'(eq.size() + wq.size()), '0);
  endtask

  task automatic do_flush();
    in_valid = 1'b0;
    out_ready = 1'b1;
    flush = 1'b1;
    #2;
    check("flush_in_ready", 256'(in_ready), 256'(0));
    tick();
    flush = 1'b0;
    repeat (3) tick();
    check("flush_no_valid", 256'(out_valid), 256'(0));
  endtask

  initial begin
    logic [255:0] v;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    check("rst_out_valid", 256'(out_valid), 256'(0));
    check("rst_data_out", data_out, '0);
    check("rst_in_ready", 256'(in_ready), 256'(1));
    wrt_en = 1'b0;
    #1;
    check("wrt_en_low_in_ready", 256'(in_ready), 256'(0));
    wrt_en = 1'b1;

    add_rec(16'h0000, '0);
    seal();
    drain(50, 1'b0);
    do_flush();

    add_rec(16'h0039, {160'd0, 32'hDEADBEEF, 32'h00007FFF, 32'h00000080});
    seal();
    in_valid = 1'b1;
    data_in = wq[0];
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    check("mixed_not_yet", 256'(out_valid), 256'(0));
    tick();
    check("mixed_valid", 256'(out_valid), 256'(1));
    check("mixed_data", data_out, {160'd0, 32'hDEADBEEF, 32'h00007FFF, 32'hFFFFFF80});
    drain(20, 1'b0);
    do_flush();

    rand_vals(v);
    add_rec(16'hFFFF, v);
    rand_rec();
    seal();
    in_valid = 1'b1;
    data_in = wq[0];
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("raw_split_wait", 256'(out_valid), 256'(0));
    drain(60, 1'b0);
    do_flush();

    repeat (16) add_rec(16'h0000, '0);
    repeat (256) sq.push_back(1'b1);
    seal();
    out_ready = 1'b0;
    repeat (5) begin
      in_valid = wq.size() != 0;
      data_in = wq.size() != 0 ? wq[0] : '0;
      tick();
    end
    in_valid = 1'b0;
    check("bp_in_ready_low", 256'(in_ready), 256'(0));
    check("bp_out_valid", 256'(out_valid), 256'(1));
    check("bp_pending", 256'(eq.size()), 256'(16));
    drain(100, 1'b0);
    do_flush();

    rand_vals(v);
    add_rec(16'h01FF, v);
    seal();
    drain(30, 1'b0);
    do_flush();

    rand_vals(v);
    add_rec(16'hFFFF, v);
    seal();
    in_valid = 1'b1;
    data_in = wq[0];
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wq.delete();
    eq.delete();
    check("midrst_out_valid", 256'(out_valid), 256'(0));
    check("midrst_data_out", data_out, '0);
    tick();
    check("midrst_in_ready", 256'(in_ready), 256'(1));
    repeat (3) rand_rec();
    seal();
    drain(100, 1'b0);
    do_flush();

    repeat (24) rand_rec();
    seal();
    drain(3000, 1'b1);
    do_flush();

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
